// File: rtl/fb_pkg.sv
// fb_pkg: shared types and default geometry for the framebuffer write scheduler
package fb_pkg;

   typedef enum logic [1:0] {SYNC, CAPTURE, CLEAR} state_t;

   localparam int FB_ADDRWIDTH = 17;
   localparam int FB_COLBITS   = 9;
   localparam int FB_ROWBITS   = 8;
   localparam int FB_DATAWIDTH = 4;

   localparam logic [FB_ROWBITS:0] FB_PRELOAD_PAL  = 9'h1DB;
   localparam logic [FB_ROWBITS:0] FB_PRELOAD_NTSC = 9'h1F3;

endpackage

// File: rtl/fb_write_sched_if.sv
// fb_write_sched_if: framebuffer port A write bus (address, data, write enable)
interface fb_write_sched_if
   import fb_pkg::*;
#(
   parameter int ADDRWIDTH = FB_ADDRWIDTH,
   parameter int DATAWIDTH = FB_DATAWIDTH
);

   logic [ADDRWIDTH-1:0] fb_addr;
   logic [DATAWIDTH-1:0] fb_data;
   logic                 fb_wren;

   modport master (output fb_addr, fb_data, fb_wren);
   modport slave  (input  fb_addr, fb_data, fb_wren);

endinterface

// File: rtl/fb_frame_lock.sv
// fb_frame_lock: sync edge detection, VSync qualification and row/column counters
module fb_frame_lock
   import fb_pkg::*;
#(
   parameter int COLBITS = FB_COLBITS,
   parameter int ROWBITS = FB_ROWBITS
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ce_pix,
   input  logic               hs,
   input  logic               vs,
   input  logic               hblank,
   input  logic               vblank,
   input  logic [ROWBITS:0]   preload,
   output logic [ROWBITS:0]   row,
   output logic [COLBITS-1:0] col,
   output logic               frame_start
);

   logic old_hs, old_vs, old_hblank, vs_detect;
   logic vs_rise, vs_fall, hs_rise, hb_fall;

   assign vs_rise     = ce_pix & vs & ~old_vs;
   assign vs_fall     = ce_pix & ~vs & old_vs;
   assign hs_rise     = ce_pix & hs & ~old_hs;
   assign hb_fall     = ce_pix & ~hblank & old_hblank;
   // a VSync only counts as a frame start once an HSync outside vblank was seen since the last VSync
   assign frame_start = vs_rise & vs_detect;

   // edge history, frame-lock qualifier and raster counters, all advanced on pixel enables
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         old_hs     <= 1'b0;
         old_vs     <= 1'b0;
         old_hblank <= 1'b0;
         vs_detect  <= 1'b0;
         row        <= '0;
         col        <= '0;
      end else if (ce_pix) begin
         old_hs     <= hs;
         old_vs     <= vs;
         old_hblank <= hblank;
         vs_detect  <= vs_fall ? 1'b0 : frame_start ? vs_detect : hs_rise ? ~vblank : vs_detect;
         row        <= frame_start ? preload : hb_fall ? row + 1'b1 : row;
         col        <= hb_fall ? '0 : col + 1'b1;
      end
   end

endmodule

// File: rtl/fb_write_sched.sv
// fb_write_sched: arbitrates framebuffer port A between live capture and the sweep-clear engine
module fb_write_sched
   import fb_pkg::*;
#(
   parameter int ADDRWIDTH      = FB_ADDRWIDTH,
   parameter int COLBITS        = FB_COLBITS,
   parameter int ROWBITS        = FB_ROWBITS,
   parameter int DATAWIDTH      = FB_DATAWIDTH,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                 CLK_VIDEO,
   input  logic                 reset_n,
   input  logic                 ce_pix,
   input  logic                 hs,
   input  logic                 vs,
   input  logic                 hblank,
   input  logic                 vblank,
   input  logic [DATAWIDTH-1:0] pix_in,
   input  logic                 vfreq50hz,
   input  logic [ROWBITS:0]     firstlinepal,
   input  logic [ROWBITS:0]     firstlinentsc,
   input  logic                 clear_req,
   fb_write_sched_if.master     fb,
   output logic                 clear_busy,
   output logic                 locked,
   output logic                 frame_pulse
);

   state_t               state, state_nx;
   logic [ADDRWIDTH-1:0] sweep, sweep_nx, addr_nx;
   logic [DATAWIDTH-1:0] data_nx;
   logic                 wren_nx;
   logic [ROWBITS:0]     row;
   logic [COLBITS-1:0]   col;
   logic                 frame_start;

   fb_frame_lock #(.COLBITS(COLBITS), .ROWBITS(ROWBITS)) u_lock (
      .clk         (CLK_VIDEO),
      .rst_n       (reset_n),
      .ce_pix      (ce_pix),
      .hs          (hs),
      .vs          (vs),
      .hblank      (hblank),
      .vblank      (vblank),
      .preload     (vfreq50hz ? firstlinepal : firstlinentsc),
      .row         (row),
      .col         (col),
      .frame_start (frame_start)
   );

   assign clear_busy = state == CLEAR;
   assign locked     = state == CAPTURE;

   // next state and next port-A word; a clear request pre-empts everything and writes address 0 at once
   always_comb begin
      state_nx = state;
      sweep_nx = sweep;
      addr_nx  = fb.fb_addr;
      data_nx  = fb.fb_data;
      wren_nx  = 1'b0;
      if (clear_req) begin
         state_nx = CLEAR;
         sweep_nx = ADDRWIDTH'(1);
         addr_nx  = '0;
         data_nx  = '0;
         wren_nx  = 1'b1;
      end else begin
         case (state)
            SYNC: state_nx = frame_start ? CAPTURE : SYNC;
            CAPTURE: begin
               if (ce_pix && !row[ROWBITS]) begin
                  addr_nx = {row[ROWBITS-1:0], col};
                  data_nx = pix_in;
                  wren_nx = 1'b1;
               end
            end
            CLEAR: begin
               addr_nx  = sweep;
               data_nx  = '0;
               wren_nx  = 1'b1;
               sweep_nx = sweep + 1'b1;
               state_nx = &sweep ? SYNC : CLEAR;
            end
            default: state_nx = SYNC;
         endcase
      end
   end

   // state, sweep pointer and registered port-A outputs
   always_ff @(posedge CLK_VIDEO or negedge reset_n) begin
      if (!reset_n) begin
         state       <= CLEAR_ON_RESET ? CLEAR : SYNC;
         sweep       <= '0;
         fb.fb_addr  <= '0;
         fb.fb_data  <= '0;
         fb.fb_wren  <= 1'b0;
         frame_pulse <= 1'b0;
      end else begin
         state       <= state_nx;
         sweep       <= sweep_nx;
         fb.fb_addr  <= addr_nx;
         fb.fb_data  <= data_nx;
         fb.fb_wren  <= wren_nx;
         frame_pulse <= frame_start;
      end
   end

endmodule
